// File: rtl/pla_trig_pipe_if.sv
// pla_trig_pipe_if: valid/ready bundle for the pipelined sine/cosine unit.
//  Upstream side : in_valid, in_ready, mode, x (signed Q(WI1.WF1) radians)
//  Downstream    : out_valid, out_ready, y (signed Q(WI2.WF2))
//  master modport = the block driving angles and consuming results,
//  slave modport  = the trig unit itself.
interface pla_trig_pipe_if #(
    parameter int WI1 = 4,
    parameter int WF1 = 12,
    parameter int WI2 = 2,
    parameter int WF2 = 14
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      mode;
    logic signed [WI1+WF1-1:0] x;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [WI2+WF2-1:0] y;

    modport master (
        output in_valid, mode, x, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, mode, x, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/pla_trig_pipe.sv
// pla_trig_pipe: 5-stage piecewise-linear sin/cos with valid/ready flow control.
//  S1 range-reduce x (+3pi/2 for sin) into [0,2pi)
//  S2 fold onto the first quarter wave of cos, split into segment index / offset
//  S3 registered coefficient read {slope a, intercept b}
//  S4 a*offset, rounded half-up to WF2 fraction bits
//  S5 b + product, quadrant sign, saturation -> y
// Ports:
//  CLK, RST_N : clock, asynchronous active-low reset
//  io         : pla_trig_pipe_if.slave (in_valid/in_ready/mode/x, out_valid/out_ready/y)
// The chord table (cos at segment ends, slope between them) is built at
// elaboration from an integer Taylor series, so no external image is needed.
module pla_trig_pipe #(
    parameter int WI1  = 4,
    parameter int WF1  = 12,
    parameter int WI2  = 2,
    parameter int WF2  = 14,
    parameter int WIDX = 6
) (
    input  logic           CLK,
    input  logic           RST_N,
    pla_trig_pipe_if.slave io
);
    localparam int XW     = WI1 + WF1;
    localparam int TW     = XW + 2;          // wrap arithmetic, never overflows
    localparam int YW     = WI2 + WF2;
    localparam int RW     = WF1 + 1;         // folded angle, 1 int + WF1 frac
    localparam int DW     = WF1 - WIDX + 1;  // offset within a segment
    localparam int PW     = YW + DW + 1;     // signed a * unsigned dr
    localparam int STAGES = 4;
    localparam int QF     = 28;              // fraction bits of the table generator

    localparam logic [63:0] PI_Q60 = 64'h3243F6A8885A308D;

    // round(k*pi/2 * 2^WF1)
    function automatic int qpi(input int k);
        logic [63:0] v;
        v = (PI_Q60 * 64'(k)) >> 1;
        v = (v + (64'd1 << (59 - WF1))) >> (60 - WF1);
        return int'(v);
    endfunction

    // cos(t), t and result in Q(QF); t <= 2 keeps every product inside 63 bits
    function automatic longint cos_q(input longint t);
        longint t2, term, sum;
        t2   = (t * t) >>> QF;
        term = 64'sd1 <<< QF;
        sum  = term;
        for (int k = 1; k <= 12; k++) begin
            term = -((term * t2) >>> QF) / longint'((2 * k - 1) * (2 * k));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic longint q_round(input longint v, input int sh);
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

    localparam logic signed [TW-1:0] C_HPI  = TW'(qpi(1));
    localparam logic signed [TW-1:0] C_PI   = TW'(qpi(2));
    localparam logic signed [TW-1:0] C_3HPI = TW'(qpi(3));
    localparam logic signed [TW-1:0] C_2PI  = TW'(qpi(4));
    localparam logic signed [PW-1:0] PHALF  = PW'(2 ** (WF1 - 1));
    localparam logic signed [YW+1:0] YMAX   = (YW+2)'(2 ** (YW - 1) - 1);
    localparam logic signed [YW+1:0] YMIN   = (YW+2)'(-(2 ** (YW - 1)));

    // Chord table: b = cos(i*h), a = (cos((i+1)h) - cos(i*h)) / h, h = 2^(1-WIDX).
    // Segment starts are exact, so angles on segment boundaries hit b directly.
    logic signed [YW-1:0] lut_a [2**WIDX];
    logic signed [YW-1:0] lut_b [2**WIDX];
    for (genvar i = 0; i < 2**WIDX; i++) begin : g_lut
        localparam longint C0 = cos_q(longint'(i) <<< (QF + 1 - WIDX));
        localparam longint C1 = cos_q(longint'(i + 1) <<< (QF + 1 - WIDX));
        localparam logic signed [YW-1:0] LB = YW'(q_round(C0, QF - WF2));
        localparam logic signed [YW-1:0] LA = YW'(q_round((C1 - C0) <<< (WIDX - 1), QF - WF2));
        assign lut_b[i] = LB;
        assign lut_a[i] = LA;
    end

    // vld_pipe[k] = stage k+1 holds a sample; vld_pipe[STAGES] is out_valid
    logic [STAGES:0]       vld_pipe;
    logic                  adv;

    logic signed [TW-1:0]  th_c, s1_th;
    logic [RW-1:0]         r_c;
    logic                  neg_c;
    logic [WIDX-1:0]       s2_idx;
    logic [DW-1:0]         s2_dr, s3_dr;
    logic                  s2_neg, s3_neg, s4_neg;
    logic signed [YW-1:0]  s3_a, s3_b, s4_b, s4_prod, y_d, y_q;
    logic signed [PW-1:0]  p_c;
    logic signed [YW+1:0]  sum_c;

    assign adv          = !vld_pipe[STAGES] | io.out_ready;
    assign io.in_ready  = adv;
    assign io.out_valid = vld_pipe[STAGES];
    assign io.y         = y_q;

    // S1: sin(x) = cos(x + 3pi/2); two 2pi corrections cover the full input range
    always_comb begin
        th_c = TW'(io.x);
        if (io.mode) th_c = th_c + C_3HPI;
        if (th_c[TW-1]) begin
            th_c = th_c + C_2PI;
            if (th_c[TW-1]) th_c = th_c + C_2PI;
        end else if (th_c >= C_2PI) begin
            th_c = th_c - C_2PI;
            if (th_c >= C_2PI) th_c = th_c - C_2PI;
        end
    end

    // S2: quarter-wave fold; boundaries fall into the upper quadrant
    always_comb begin
        r_c   = '0;
        neg_c = 1'b0;
        if (s1_th < C_HPI) begin
            r_c = RW'(s1_th);
        end else if (s1_th < C_PI) begin
            r_c   = RW'(C_PI - s1_th);
            neg_c = 1'b1;
        end else if (s1_th < C_3HPI) begin
            r_c   = RW'(s1_th - C_PI);
            neg_c = 1'b1;
        end else begin
            r_c = RW'(C_2PI - s1_th);
        end
    end

    // S4: slope times offset; offset carries WF1 fraction bits
    assign p_c = PW'(s3_a) * PW'($signed({1'b0, s3_dr}));

    // S5: intercept + product, quadrant sign, clamp
    always_comb begin
        sum_c = (YW+2)'(s4_b) + (YW+2)'(s4_prod);
        if (s4_neg) sum_c = -sum_c;
        if (sum_c > YMAX)      y_d = YW'(YMAX);
        else if (sum_c < YMIN) y_d = YW'(YMIN);
        else                   y_d = YW'(sum_c);
    end

    // Data registers load only when their incoming slot is valid, so a held
    // or empty slot never disturbs downstream values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_pipe <= '0;
            s1_th    <= '0;
            s2_idx   <= '0;
            s2_dr    <= '0;
            s2_neg   <= 1'b0;
            s3_a     <= '0;
            s3_b     <= '0;
            s3_dr    <= '0;
            s3_neg   <= 1'b0;
            s4_b     <= '0;
            s4_prod  <= '0;
            s4_neg   <= 1'b0;
            y_q      <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], io.in_valid};
            if (io.in_valid) s1_th <= th_c;
            if (vld_pipe[0]) begin
                s2_idx <= r_c[WF1 -: WIDX];
                s2_dr  <= r_c[DW-1:0];
                s2_neg <= neg_c;
            end
            if (vld_pipe[1]) begin
                s3_a   <= lut_a[s2_idx];
                s3_b   <= lut_b[s2_idx];
                s3_dr  <= s2_dr;
                s3_neg <= s2_neg;
            end
            if (vld_pipe[2]) begin
                s4_b    <= s3_b;
                s4_prod <= YW'((p_c + PHALF) >>> WF1);
                s4_neg  <= s3_neg;
            end
            if (vld_pipe[3]) y_q <= y_d;
        end
    end
endmodule

// File: tb/tb_pla_trig_pipe.sv
// tb_pla_trig_pipe: scoreboard bench for pla_trig_pipe.
// Accepted inputs push a double-precision sin/cos expectation; an independent
// monitor pops one per output transfer and checks it within +/-4 LSB.
`timescale 1ns/1ps
module tb_pla_trig_pipe;
    localparam int WI1 = 4, WF1 = 12, WI2 = 2, WF2 = 14, WIDX = 6;
    localparam int XW  = WI1 + WF1;
    localparam int TOL = 4;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    pla_trig_pipe_if #(.WI1(WI1), .WF1(WF1), .WI2(WI2), .WF2(WF2)) intf ();

    pla_trig_pipe #(.WI1(WI1), .WF1(WF1), .WI2(WI2), .WF2(WF2), .WIDX(WIDX)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .io   (intf.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct { bit m; int x; int exp; } item_t;

    item_t src_q[$];
    item_t sb_q[$];
    int    acc_cyc_q[$];
    int    out_cyc_q[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    int    n_out = 0;
    int    smp_ov, smp_y, smp_ir;

    function automatic int golden(input bit m, input int x);
        real a, v;
        int  r;
        a = real'(x) / (2.0 ** WF1);
        v = (m ? $sin(a) : $cos(a)) * (2.0 ** WF2);
        r = $rtoi($floor(v + 0.5));
        if (r > 2 ** (WI2 + WF2 - 1) - 1) r = 2 ** (WI2 + WF2 - 1) - 1;
        if (r < -(2 ** (WI2 + WF2 - 1))) r = -(2 ** (WI2 + WF2 - 1));
        return r;
    endfunction

    function automatic item_t mk(input bit m, input int x);
        item_t it;
        it.m   = m;
        it.x   = x;
        it.exp = golden(m, x);
        return it;
    endfunction

    task automatic chk_eq(input string nm, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    task automatic chk_tol(input string nm, input int act, input int req);
        n_chk++;
        if (act >= req - TOL && act <= req + TOL) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, req, TOL);
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // monitor: one pop per completed output transfer
    initial forever begin
        item_t it;
        @(negedge CLK);
        if (RST_N && intf.out_valid && intf.out_ready) begin
            n_out++;
            out_cyc_q.push_back(cyc);
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_output: y=%0d arrived with nothing outstanding", int'(intf.y));
            end else begin
                it = sb_q.pop_front();
                chk_tol($sformatf("y mode=%0d x=%0d", it.m, it.x), int'(intf.y), it.exp);
            end
        end
    end

    // One clock: present head of src_q if allowed, record acceptance at negedge.
    task automatic tick(input bit ordy, input bit allow, output bit acc);
        intf.out_ready = ordy;
        if (allow && src_q.size() > 0) begin
            intf.in_valid = 1'b1;
            intf.mode     = src_q[0].m;
            intf.x        = XW'(src_q[0].x);
        end else begin
            intf.in_valid = 1'b0;
        end
        @(negedge CLK);
        smp_ov = int'(intf.out_valid);
        smp_y  = int'(intf.y);
        smp_ir = int'(intf.in_ready);
        acc    = intf.in_valid && intf.in_ready;
        if (acc) begin
            sb_q.push_back(src_q.pop_front());
            acc_cyc_q.push_back(cyc);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run_src(input string nm, input int max);
        int n;
        bit acc;
        n = 0;
        while (src_q.size() > 0 && n < max) begin
            tick(1'b1, 1'b1, acc);
            n++;
        end
        chk_eq({nm, " inputs_left"}, src_q.size(), 0);
    endtask

    task automatic drain(input string nm);
        int n;
        bit acc;
        n = 0;
        while (sb_q.size() > 0 && n < 200) begin
            tick(1'b1, 1'b0, acc);
            n++;
        end
        chk_eq({nm, " outputs_missing"}, sb_q.size(), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc, pend;
        int y0, snap, sz, xs;
        intf.in_valid  = 1'b0;
        intf.mode      = 1'b0;
        intf.x         = '0;
        intf.out_ready = 1'b0;

        // reset state
        repeat (3) @(posedge CLK);
        #1;
        chk_eq("reset out_valid", int'(intf.out_valid), 0);
        chk_eq("reset y", int'(intf.y), 0);
        chk_eq("reset in_ready", int'(intf.in_ready), 1);
        #2 RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // directed points: quadrant edges, wrap, extreme input
        src_q.push_back(mk(0, 0));
        src_q.push_back(mk(0, 6434));
        src_q.push_back(mk(0, 12868));
        src_q.push_back(mk(1, 6434));
        src_q.push_back(mk(1, -6434));
        src_q.push_back(mk(1, 0));
        src_q.push_back(mk(0, 25736));
        src_q.push_back(mk(0, -25736));
        src_q.push_back(mk(0, 32767));
        src_q.push_back(mk(0, -32768));
        src_q.push_back(mk(1, 32767));
        src_q.push_back(mk(1, 19302));
        run_src("directed", 50);
        drain("directed");

        // back-to-back sweep, both modes
        acc_cyc_q.delete();
        out_cyc_q.delete();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 256; i++) src_q.push_back(mk(m[0], i * 100));
        run_src("sweep", 600);
        drain("sweep");
        sz = out_cyc_q.size();
        chk_eq("sweep output count", sz, 512);
        if (sz > 0 && acc_cyc_q.size() > 0) begin
            chk_eq("sweep first latency", out_cyc_q[0] - acc_cyc_q[0], 5);
            chk_eq("sweep output span", out_cyc_q[sz-1] - out_cyc_q[0], sz - 1);
        end

        // backpressure: stall 3 cycles with a valid output waiting
        for (int i = 0; i < 14; i++) src_q.push_back(mk($urandom_range(0, 1), int'($urandom_range(0, 65535)) - 32768));
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, acc);
        tick(1'b0, 1'b1, acc);
        y0 = smp_y;
        chk_eq("stall out_valid 0", smp_ov, 1);
        chk_eq("stall in_ready 0", smp_ir, 0);
        for (int k = 1; k < 3; k++) begin
            tick(1'b0, 1'b1, acc);
            chk_eq($sformatf("stall out_valid %0d", k), smp_ov, 1);
            chk_eq($sformatf("stall y %0d", k), smp_y, y0);
            chk_eq($sformatf("stall in_ready %0d", k), smp_ir, 0);
        end
        run_src("backpressure", 50);
        drain("backpressure");

        // random valid/ready traffic; an offered item stays until taken
        pend = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (src_q.size() == 0) begin
                xs = int'($urandom_range(0, 65535)) - 32768;
                src_q.push_back(mk($urandom_range(0, 1), xs));
            end
            tick($urandom_range(0, 3) != 0, pend || ($urandom_range(0, 9) < 6), acc);
            pend = intf.in_valid && !acc;
        end
        src_q.delete();
        drain("random");

        // reset with samples in flight
        for (int i = 0; i < 10; i++) src_q.push_back(mk($urandom_range(0, 1), int'($urandom_range(0, 65535)) - 32768));
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, acc);
        #2;
        chk_eq("pre-reset out_valid", int'(intf.out_valid), 1);
        RST_N = 1'b0;
        #1;
        chk_eq("mid reset out_valid", int'(intf.out_valid), 0);
        chk_eq("mid reset y", int'(intf.y), 0);
        chk_eq("mid reset in_ready", int'(intf.in_ready), 1);
        sb_q.delete();
        src_q.delete();
        intf.in_valid = 1'b0;
        snap = n_out;
        @(posedge CLK);
        #3 RST_N = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 15; i++) tick(1'b1, 1'b0, acc);
        chk_eq("no stale output after reset", n_out, snap);

        // pipeline usable again
        src_q.push_back(mk(0, 12868));
        src_q.push_back(mk(1, 3000));
        src_q.push_back(mk(0, -20000));
        run_src("post-reset", 20);
        drain("post-reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
